// File: rtl/sram_resp.sv
// sram_resp: bridges single CPU read/write requests in the upper half of the
// address map onto an asynchronous 16-bit SRAM. Each accepted access runs
// IDLE -> SETUP -> STROBE (WAIT_CYC cycles) -> DONE and then returns to IDLE.
// Requests that arrive while an access is running are dropped and raise a
// sticky error flag.
module sram_resp #(
  parameter int unsigned WAIT_CYC = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [15:0] addr_i,
  input  logic        we_i,
  input  logic        re_i,
  input  logic [15:0] wdata_i,
  output logic [15:0] rdata_o,
  output logic        rdy_o,
  output logic        busy_o,
  output logic        err_o,
  output logic [14:0] sram_addr_o,
  inout  wire  [15:0] sram_dq_io,
  output logic        sram_ce_n_o,
  output logic        sram_oe_n_o,
  output logic        sram_we_n_o,
  output logic        sram_ub_n_o,
  output logic        sram_lb_n_o
);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, DONE} state_e;

  // Strobe counter reload value: counts WAIT_CYC-1 down to 0 inside STROBE.
  localparam logic [3:0] WaitLoad = 4'(WAIT_CYC - 1);

  state_e      state_q, state_d;
  logic [3:0]  waitCnt_q, waitCnt_d;
  logic [14:0] addr_q;
  logic [15:0] wdata_q;
  logic [15:0] rdata_q;
  logic        isWrite_q;
  logic        err_q;
  logic        dqEn;

  logic reqValid;
  logic accept;
  logic strobeLast;

  assign reqValid   = addr_i[15] & (we_i | re_i);
  assign accept     = reqValid & (state_q == IDLE);
  assign strobeLast = (state_q == STROBE) && (waitCnt_q == 4'd0);

  // State and strobe counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      waitCnt_q <= 4'd0;
    end else begin
      state_q   <= state_d;
      waitCnt_q <= waitCnt_d;
    end
  end

  // Next-state and counter logic: SETUP and DONE are one cycle each.
  always_comb begin
    state_d   = state_q;
    waitCnt_d = waitCnt_q;
    case (state_q)
      IDLE: begin
        if (accept) state_d = SETUP;
      end
      SETUP: begin
        state_d   = STROBE;
        waitCnt_d = WaitLoad;
      end
      STROBE: begin
        if (waitCnt_q == 4'd0) begin
          state_d = DONE;
        end else begin
          waitCnt_d = waitCnt_q - 4'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Request latch, read capture and sticky protocol error.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q    <= 15'd0;
      wdata_q   <= 16'd0;
      isWrite_q <= 1'b0;
      rdata_q   <= 16'd0;
      err_q     <= 1'b0;
    end else begin
      if (accept) begin
        addr_q    <= addr_i[14:0];
        wdata_q   <= wdata_i;
        isWrite_q <= we_i;
      end
      if (strobeLast && !isWrite_q) begin
        rdata_q <= sram_dq_io;
      end
      if (reqValid && ((state_q != IDLE) || (we_i && re_i))) begin
        err_q <= 1'b1;
      end
    end
  end

  // SRAM control strobes and handshake outputs decoded from the current state.
  always_comb begin
    busy_o      = 1'b0;
    rdy_o       = 1'b0;
    sram_ce_n_o = 1'b1;
    sram_oe_n_o = 1'b1;
    sram_we_n_o = 1'b1;
    sram_ub_n_o = 1'b1;
    sram_lb_n_o = 1'b1;
    dqEn        = 1'b0;
    case (state_q)
      SETUP: begin
        busy_o      = 1'b1;
        sram_ce_n_o = 1'b0;
        sram_ub_n_o = 1'b0;
        sram_lb_n_o = 1'b0;
        dqEn        = isWrite_q;
      end
      STROBE: begin
        busy_o      = 1'b1;
        sram_ce_n_o = 1'b0;
        sram_ub_n_o = 1'b0;
        sram_lb_n_o = 1'b0;
        sram_oe_n_o = isWrite_q;
        sram_we_n_o = ~isWrite_q;
        dqEn        = isWrite_q;
      end
      DONE: begin
        busy_o = 1'b1;
        rdy_o  = 1'b1;
        dqEn   = isWrite_q;
      end
      default: begin
        busy_o = 1'b0;
      end
    endcase
  end

  assign sram_addr_o = addr_q;
  assign rdata_o     = rdata_q;
  assign err_o       = err_q;
  assign sram_dq_io  = dqEn ? wdata_q : 16'hzzzz;

endmodule

// File: tb/tb_sram_resp.sv
// Testbench for sram_resp. Instance A runs with WAIT_CYC=2 for directed and
// randomized traffic; instance B runs with WAIT_CYC=1 for the reset-abort
// scenario. Each instance talks to its own behavioural SRAM; expected values
// come from a transaction-level model (reference memory, expected rdata and
// err) and from the cycle offset since the request was sampled.
module tb_sram_resp;

  localparam int WA = 2;
  localparam int WB = 1;

  int checks = 0;
  int failures = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A signals
  logic        rstN;
  logic [15:0] addr, wdata, rdata;
  logic        we, re, rdy, busy, err;
  logic [14:0] sramAddr;
  wire  [15:0] sramDq;
  logic        ceN, oeN, weN, ubN, lbN;

  // Instance B signals
  logic        rstBN;
  logic [15:0] addrB, wdataB, rdataB;
  logic        weB, reB, rdyB, busyB, errB;
  logic [14:0] sramAddrB;
  wire  [15:0] sramDqB;
  logic        ceBN, oeBN, weBN, ubBN, lbBN;

  // Behavioural SRAMs and the reference contents for instance A
  bit [15:0] memA [0:32767];
  bit [15:0] memB [0:32767];
  bit [15:0] refMem [0:32767];
  logic [15:0] expRdata;
  logic        expErr;

  sram_resp #(.WAIT_CYC(WA)) u_dutA (
    .clk_i(clk), .rst_ni(rstN), .addr_i(addr), .we_i(we), .re_i(re),
    .wdata_i(wdata), .rdata_o(rdata), .rdy_o(rdy), .busy_o(busy), .err_o(err),
    .sram_addr_o(sramAddr), .sram_dq_io(sramDq), .sram_ce_n_o(ceN),
    .sram_oe_n_o(oeN), .sram_we_n_o(weN), .sram_ub_n_o(ubN), .sram_lb_n_o(lbN)
  );

  sram_resp #(.WAIT_CYC(WB)) u_dutB (
    .clk_i(clk), .rst_ni(rstBN), .addr_i(addrB), .we_i(weB), .re_i(reB),
    .wdata_i(wdataB), .rdata_o(rdataB), .rdy_o(rdyB), .busy_o(busyB), .err_o(errB),
    .sram_addr_o(sramAddrB), .sram_dq_io(sramDqB), .sram_ce_n_o(ceBN),
    .sram_oe_n_o(oeBN), .sram_we_n_o(weBN), .sram_ub_n_o(ubBN), .sram_lb_n_o(lbBN)
  );

  // SRAM A: drives the bus while selected and output-enabled, stores on write strobe
  assign sramDq = (!ceN && !oeN) ? memA[sramAddr] : 16'hzzzz;
  always @(posedge clk) if (!ceN && !weN) memA[sramAddr] <= sramDq;

  // SRAM B: same behaviour for the second instance
  assign sramDqB = (!ceBN && !oeBN) ? memB[sramAddrB] : 16'hzzzz;
  always @(posedge clk) if (!ceBN && !weBN) memB[sramAddrB] <= sramDqB;

  // Output and write strobes must never overlap on either instance
  always @(negedge clk) begin
    checks++;
    if ((!oeN && !weN) || (!oeBN && !weBN)) begin
      failures++;
      $display("[TB] FAIL strobe_overlap actual A oe_n=%b we_n=%b B oe_n=%b we_n=%b required never both low",
               oeN, weN, oeBN, weBN);
    end
  end

  // Expected {busy, rdy, ce_n, oe_n, we_n, ub_n, lb_n} k cycles after the
  // request edge for an accepted access with the given strobe length
  function automatic logic [6:0] expCtl(input int k, input int w, input bit isW);
    if (k == 1)          return 7'b1001100;
    else if (k <= 1 + w) return isW ? 7'b1001000 : 7'b1000100;
    else if (k == 2 + w) return 7'b1111111;
    else                 return 7'b0011111;
  endfunction

  // Undriven bus may read as z or 0; write data is always nonzero
  function automatic bit isUndriven(input logic [15:0] v);
    return (v === 16'hzzzz) || (v === 16'h0000);
  endfunction

  // One access on instance A, optionally with a second request injected
  // k cycles after the first was sampled; checked every cycle until idle
  task automatic runAccess(input logic [15:0] a, input logic w, input logic r,
                           input logic [15:0] d, input int injAt,
                           input logic [15:0] injA, input logic injW, input logic injR);
    bit acc, injQual;
    logic [6:0] eCtl;
    acc = a[15] && (w || r);
    injQual = injA[15] && (injW || injR);
    @(negedge clk);
    addr = a; we = w; re = r; wdata = d;
    for (int k = 1; k <= WA + 3; k++) begin
      @(negedge clk);
      we = 1'b0; re = 1'b0;
      if (acc && injAt == k) begin
        addr = injA; we = injW; re = injR; wdata = ~d;
      end
      if (acc && k == 1 && w && r) expErr = 1'b1;
      if (acc && injQual && injAt != 0 && k == injAt + 1) expErr = 1'b1;
      eCtl = acc ? expCtl(k, WA, w) : 7'b0011111;
      if (acc && !w && k == WA + 2) expRdata = refMem[a[14:0]];
      checks++;
      if ({busy, rdy, ceN, oeN, weN, ubN, lbN} !== eCtl) begin
        failures++;
        $display("[TB] FAIL ctrl a=%h k=%0d actual=%b required=%b", a, k,
                 {busy, rdy, ceN, oeN, weN, ubN, lbN}, eCtl);
      end
      if (acc && w && k <= WA + 2) begin
        checks++;
        if (sramDq !== d) begin
          failures++;
          $display("[TB] FAIL dq_write a=%h k=%0d actual=%h required=%h", a, k, sramDq, d);
        end
      end else if (!acc || w || k == 1 || k >= WA + 2) begin
        checks++;
        if (!isUndriven(sramDq)) begin
          failures++;
          $display("[TB] FAIL dq_hiz a=%h k=%0d actual=%h required=z", a, k, sramDq);
        end
      end
      if (acc && k <= WA + 2) begin
        checks++;
        if (sramAddr !== a[14:0]) begin
          failures++;
          $display("[TB] FAIL sram_addr a=%h k=%0d actual=%h required=%h", a, k, sramAddr, a[14:0]);
        end
      end
      checks++;
      if (rdata !== expRdata) begin
        failures++;
        $display("[TB] FAIL rdata a=%h k=%0d actual=%h required=%h", a, k, rdata, expRdata);
      end
      checks++;
      if (err !== expErr) begin
        failures++;
        $display("[TB] FAIL err a=%h k=%0d actual=%b required=%b", a, k, err, expErr);
      end
    end
    if (acc && w) refMem[a[14:0]] = d;
  endtask

  // Asynchronous reset of instance A with all outputs at their reset values
  task automatic test_reset();
    @(negedge clk);
    #2 rstN = 1'b0;
    addr = 16'h0; we = 1'b0; re = 1'b0; wdata = 16'h0;
    #1;
    expRdata = 16'h0;
    expErr = 1'b0;
    checks++;
    if ({busy, rdy, ceN, oeN, weN, ubN, lbN} !== 7'b0011111) begin
      failures++;
      $display("[TB] FAIL reset_ctrl actual=%b required=0011111", {busy, rdy, ceN, oeN, weN, ubN, lbN});
    end
    checks++;
    if (sramAddr !== 15'h0 || rdata !== 16'h0 || err !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_regs actual addr=%h rdata=%h err=%b required 0/0/0", sramAddr, rdata, err);
    end
    checks++;
    if (!isUndriven(sramDq)) begin
      failures++;
      $display("[TB] FAIL reset_dq actual=%h required=z", sramDq);
    end
    repeat (2) @(negedge clk);
    rstN = 1'b1;
  endtask

  task automatic test_write();
    runAccess(16'h8005, 1'b1, 1'b0, 16'hBEEF, 0, 16'h0, 1'b0, 1'b0);
  endtask

  task automatic test_read();
    runAccess(16'h8005, 1'b0, 1'b1, 16'h0, 0, 16'h0, 1'b0, 1'b0);
    runAccess(16'h8006, 1'b1, 1'b0, 16'h1111, 0, 16'h0, 1'b0, 1'b0);
  endtask

  task automatic test_ignored();
    runAccess(16'h0005, 1'b0, 1'b1, 16'h0, 0, 16'h0, 1'b0, 1'b0);
    runAccess(16'h0005, 1'b1, 1'b0, 16'h7777, 0, 16'h0, 1'b0, 1'b0);
    runAccess(16'h8005, 1'b0, 1'b1, 16'h0, 0, 16'h0, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    runAccess(16'h8005, 1'b0, 1'b1, 16'h0, 2, 16'h8006, 1'b0, 1'b1);
    runAccess(16'h8006, 1'b0, 1'b1, 16'h0, 0, 16'h0, 1'b0, 1'b0);
  endtask

  task automatic test_collision();
    runAccess(16'hFFFF, 1'b1, 1'b1, 16'h1357, 0, 16'h0, 1'b0, 1'b0);
    runAccess(16'hFFFF, 1'b0, 1'b1, 16'h0, 0, 16'h0, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    logic [15:0] a, d, injA;
    logic w, r, injW, injR;
    int op, injAt;
    for (int i = 0; i < 60; i++) begin
      a = {($urandom_range(0, 3) != 0), 15'($urandom_range(0, 7))};
      d = 16'($urandom_range(1, 65535));
      op = $urandom_range(0, 9);
      w = (op <= 3) || (op == 8);
      r = (op >= 4 && op <= 8);
      injAt = ($urandom_range(0, 2) == 0) ? $urandom_range(1, WA + 2) : 0;
      injA = {($urandom_range(0, 1) == 1), 15'($urandom_range(0, 7))};
      injW = ($urandom_range(0, 1) == 1);
      injR = ($urandom_range(0, 1) == 1);
      runAccess(a, w, r, d, injAt, injA, injW, injR);
    end
  endtask

  // Instance B: reset during the write strobe aborts at once; the next read
  // completes with the one-cycle strobe timing
  task automatic test_reset_abort();
    logic [6:0] eCtl;
    @(negedge clk);
    rstBN = 1'b1;
    // complete write of a known value
    @(negedge clk);
    addrB = 16'h8003; weB = 1'b1; reB = 1'b0; wdataB = 16'h1234;
    for (int k = 1; k <= WB + 3; k++) begin
      @(negedge clk);
      weB = 1'b0;
      eCtl = expCtl(k, WB, 1'b1);
      checks++;
      if ({busyB, rdyB, ceBN, oeBN, weBN, ubBN, lbBN} !== eCtl) begin
        failures++;
        $display("[TB] FAIL b_write_ctrl k=%0d actual=%b required=%b", k,
                 {busyB, rdyB, ceBN, oeBN, weBN, ubBN, lbBN}, eCtl);
      end
    end
    // write aborted by reset inside its strobe
    @(negedge clk);
    addrB = 16'h8003; weB = 1'b1; wdataB = 16'hDEAD;
    repeat (2) @(negedge clk);
    weB = 1'b0;
    checks++;
    if ({busyB, rdyB, ceBN, oeBN, weBN, ubBN, lbBN} !== 7'b1001000 || sramDqB !== 16'hDEAD) begin
      failures++;
      $display("[TB] FAIL b_pre_abort actual=%b dq=%h required=1001000 dq=dead",
               {busyB, rdyB, ceBN, oeBN, weBN, ubBN, lbBN}, sramDqB);
    end
    #2 rstBN = 1'b0;
    #1;
    checks++;
    if ({busyB, rdyB, ceBN, oeBN, weBN, ubBN, lbBN} !== 7'b0011111) begin
      failures++;
      $display("[TB] FAIL b_abort_ctrl actual=%b required=0011111", {busyB, rdyB, ceBN, oeBN, weBN, ubBN, lbBN});
    end
    checks++;
    if (!isUndriven(sramDqB) || rdataB !== 16'h0 || errB !== 1'b0) begin
      failures++;
      $display("[TB] FAIL b_abort_regs actual dq=%h rdata=%h err=%b required z/0/0", sramDqB, rdataB, errB);
    end
    @(negedge clk);
    rstBN = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++;
      if ({busyB, rdyB} !== 2'b00) begin
        failures++;
        $display("[TB] FAIL b_no_rdy k=%0d actual busy/rdy=%b required=00", k, {busyB, rdyB});
      end
    end
    // read after release: rdy two cycles after SETUP, old data intact
    addrB = 16'h8003; reB = 1'b1;
    for (int k = 1; k <= WB + 3; k++) begin
      @(negedge clk);
      reB = 1'b0;
      eCtl = expCtl(k, WB, 1'b0);
      checks++;
      if ({busyB, rdyB, ceBN, oeBN, weBN, ubBN, lbBN} !== eCtl) begin
        failures++;
        $display("[TB] FAIL b_read_ctrl k=%0d actual=%b required=%b", k,
                 {busyB, rdyB, ceBN, oeBN, weBN, ubBN, lbBN}, eCtl);
      end
      checks++;
      if (rdataB !== ((k >= WB + 2) ? 16'h1234 : 16'h0000)) begin
        failures++;
        $display("[TB] FAIL b_read_data k=%0d actual=%h required=%h", k, rdataB,
                 (k >= WB + 2) ? 16'h1234 : 16'h0000);
      end
    end
  endtask

  initial begin
    rstN = 1'b0; rstBN = 1'b0;
    addr = 16'h0; we = 1'b0; re = 1'b0; wdata = 16'h0;
    addrB = 16'h0; weB = 1'b0; reB = 1'b0; wdataB = 16'h0;
    expRdata = 16'h0; expErr = 1'b0;
    test_reset();
    test_write();
    test_read();
    test_ignored();
    test_back_to_back();
    test_reset();
    test_collision();
    test_reset();
    test_random();
    test_reset_abort();
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
